// File: rtl/pe_mac_accum.sv
// pe_mac_accum: multiply-accumulate unit for an Eyeriss processing element.
// Accumulates a group of cfg_len unsigned a*b products onto psum_init using a
// two-stage pipeline (registered multiply, then accumulate). Valid/ready
// handshakes are used on both the operand side and the result side.
// Optional build macro MAC_SAT_EN: when defined, the accumulator saturates to
// all-ones on carry-out. When undefined, it wraps modulo 2^ACC_W. In both
// builds the sticky ovf flag is set.
module pe_mac_accum #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 16,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ACC_W-1:0]  psum_init,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_psum,
  output logic              busy,
  output logic              ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state;
  logic [LEN_W-1:0]    cnt;
  logic [LEN_W-1:0]    len;
  logic [PROD_W-1:0]   prod;
  logic                prod_vld;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    acc_next;
  logic [LEN_W-1:0]    cnt_next;
  logic [LEN_W-1:0]    len_clamped;
  logic                beat;
  logic                start_take;

  assign beat        = in_valid && in_ready;
  assign start_take  = start && (state == IDLE);
  assign cnt_next    = cnt + LEN_ONE;
  assign len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

  // The extra top bit of sum is the carry-out of the ACC_W-bit add.
  assign sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

`ifdef MAC_SAT_EN
  assign acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  assign in_ready  = (state == ACC) && (cnt < len);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign out_psum  = acc;

  // Group sequencing: IDLE -> ACC -> DRAIN -> HOLD -> IDLE, with beat counting.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      len   <= '0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      len   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len   <= len_clamped;
            cnt   <= '0;
            state <= (len_clamped == '0) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (beat) begin
            cnt <= cnt_next;
            if (cnt_next == len) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave once the final product has been folded into acc.
          if (!prod_vld) state <= HOLD;
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: stage 1 registers the product, stage 2 accumulates it and tracks overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      ovf      <= 1'b0;
    end else if (clear) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      ovf      <= 1'b0;
    end else begin
      prod_vld <= beat;
      if (beat) prod <= in_a * in_b;
      if (start_take) begin
        acc <= psum_init;
        ovf <= 1'b0;
      end else if (prod_vld) begin
        acc <= acc_next;
        if (sum[ACC_W]) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_accum.sv
// Directed testbench for pe_mac_accum with default parameters
// (DATA_W=8, ACC_W=16, MAX_LEN=16). Inputs are driven and outputs sampled
// 1ns after each rising edge.
module tb_pe_mac_accum;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 16;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic [ACC_W-1:0]  psum_init;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_psum;
  logic              busy;
  logic              ovf;

  int total = 0;
  int bad   = 0;

  pe_mac_accum #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
    .cfg_len(cfg_len), .psum_init(psum_init),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_group(input logic [LEN_W-1:0] len, input logic [ACC_W-1:0] init);
    start = 1'b1; cfg_len = len; psum_init = init;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid; an expired bound counts as a failed comparison.
  task automatic wait_valid(input int max_cycles, input string name);
    int n = 0;
    while (!out_valid && n < max_cycles) begin
      tick();
      n++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s: out_valid got %b after %0d cycles, expected 1", name, out_valid, n);
    end
  endtask

  task automatic accept_result(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s: out_valid=%b busy=%b after handshake, expected 0 0", name, out_valid, busy);
    end
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({in_ready, out_valid, busy, ovf} !== 4'b0 || out_psum !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b ov=%b busy=%b ovf=%b psum=%h, expected all 0",
               in_ready, out_valid, busy, ovf, out_psum);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    start_group(3, 16'd10);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready: in_ready=%b busy=%b, expected 1 1", in_ready, busy);
    end
    beat(8'd2, 8'd3);
    beat(8'd4, 8'd5);
    beat(8'd6, 8'd7);
    // Edge E just accepted the final beat.
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_after_E: in_ready=%b out_valid=%b, expected 0 0", in_ready, out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_E1: out_valid got %b expected 0", out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_psum !== 16'd78 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL b2b_result: out_valid=%b psum=%0d ovf=%b, expected 1 78 0", out_valid, out_psum, ovf);
    end
    accept_result("b2b_handshake");
  endtask

  task automatic test_empty_and_bubbles;
    start_group(0, 16'h1234);
    total++;
    if (out_valid !== 1'b1 || out_psum !== 16'h1234) begin
      bad++;
      $display("FAIL empty_group: out_valid=%b psum=%h, expected 1 1234", out_valid, out_psum);
    end
    accept_result("empty_handshake");
    start_group(2, 16'd0);
    beat(8'd3, 8'd3);
    in_a = 8'd9; in_b = 8'd9;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_psum !== 16'd9) begin
      bad++;
      $display("FAIL bubble_gap: in_ready=%b out_valid=%b psum=%0d, expected 1 0 9", in_ready, out_valid, out_psum);
    end
    beat(8'd1, 8'd1);
    wait_valid(4, "bubble_valid");
    total++;
    if (out_psum !== 16'd10) begin
      bad++;
      $display("FAIL bubble_result: psum got %0d expected 10", out_psum);
    end
    accept_result("bubble_handshake");
  endtask

  task automatic test_backpressure;
    start_group(1, 16'd5);
    beat(8'd3, 8'd4);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); cfg_len = 5'd2; psum_init = 16'd0;
      tick();
      start = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_psum !== 16'd17 || in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL backpressure_hold%0d: ov=%b psum=%0d rdy=%b busy=%b, expected 1 17 0 1",
                 i, out_valid, out_psum, in_ready, busy);
      end
    end
    accept_result("backpressure_release");
    tick();
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_idle: busy=%b in_ready=%b, expected 0 0", busy, in_ready);
    end
  endtask

  task automatic test_overflow;
    logic [ACC_W-1:0] exp_psum;
`ifdef MAC_SAT_EN
    exp_psum = 16'hFFFF;
`else
    exp_psum = 16'hFD02;
`endif
    start_group(2, 16'hFF00);
    beat(8'd255, 8'd255);
    beat(8'd1, 8'd1);
    wait_valid(4, "ovf_valid");
    total++;
    if (out_psum !== exp_psum || ovf !== 1'b1) begin
      bad++;
      $display("FAIL overflow: psum=%h ovf=%b, expected %h 1", out_psum, ovf, exp_psum);
    end
    accept_result("ovf_handshake");
    start_group(1, 16'd0);
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_cleared_on_start: ovf got %b expected 0", ovf);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_clamp;
    start_group(5'd20, 16'd0);
    for (int i = 0; i < MAX_LEN; i++) beat(8'd1, 8'd1);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL clamp_ready: in_ready got %b expected 0 after %0d beats", in_ready, MAX_LEN);
    end
    wait_valid(4, "clamp_valid");
    total++;
    if (out_psum !== 16'd16) begin
      bad++;
      $display("FAIL clamp_result: psum got %0d expected 16", out_psum);
    end
    // clear beats the output handshake in the same cycle.
    clear = 1'b1; out_ready = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_psum !== 16'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL clear_vs_handshake: ov=%b psum=%0d busy=%b, expected 0 0 0", out_valid, out_psum, busy);
    end
  endtask

  task automatic test_abort;
    // Asynchronous reset mid-ACC with ovf set and a nonzero accumulator.
    start_group(3, 16'hFF00);
    beat(8'd255, 8'd255);
    tick();
    total++;
    if (ovf !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_setup: ovf=%b busy=%b, expected 1 1", ovf, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, busy, ovf} !== 4'b0 || out_psum !== 16'h0) begin
      bad++;
      $display("FAIL async_reset: rdy=%b ov=%b busy=%b ovf=%b psum=%h, expected all 0",
               in_ready, out_valid, busy, ovf, out_psum);
    end
    tick();
    rst_n = 1'b1;
    tick();
    // clear with start in the same cycle.
    start_group(3, 16'hFF00);
    beat(8'd255, 8'd255);
    tick();
    clear = 1'b1; start = 1'b1; cfg_len = 5'd1; psum_init = 16'd7;
    tick();
    clear = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b0 || out_psum !== 16'd0 || ovf !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL clear_abort: busy=%b psum=%h ovf=%b rdy=%b, expected 0 0 0 0", busy, out_psum, ovf, in_ready);
    end
    start_group(1, 16'd0);
    beat(8'd2, 8'd2);
    wait_valid(4, "after_clear_valid");
    total++;
    if (out_psum !== 16'd4 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL after_clear_result: psum=%0d ovf=%b, expected 4 0", out_psum, ovf);
    end
    accept_result("after_clear_handshake");
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; cfg_len = '0; psum_init = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_empty_and_bubbles();
    test_backpressure();
    test_overflow();
    test_clamp();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
